btn_debounce: RTL and testbench
===============================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning the number of cycles a synchronized input must hold a new level before it is accepted (10 ms at 25 MHz).
REQ-002 SHALL have parameter CNT_W, default 18, meaning the per-button counter width; it SHALL satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock (cpu_clk domain); all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: a synchronous, active-low reset.
REQ-005 SHALL have port button, input, 5 bits: raw asynchronous board buttons, high = pressed.
REQ-006 SHALL have port addr, input, 12 bits: bus offset within the 0xFFFF_F000 peripheral page.
REQ-007 SHALL have port wen, input, 1 bit: bus write enable.
REQ-008 SHALL have port wdata, input, 32 bits: bus write data.
REQ-009 SHALL have port rdata, output, 32 bits: bus read data toward the bridge.
REQ-010 SHALL have port btn_stable, output, 5 bits: the debounced button levels.
REQ-011 SHALL have port btn_rise, output, 5 bits: a one-cycle pulse on each debounced 0->1 transition.

Function
REQ-012 Each button bit SHALL pass through a two-flop synchronizer (sync1 -> sync2) before any other logic.
REQ-013 Each bit SHALL keep a counter cnt, updated as follows:
- sync2 == stable: cnt <= 0.
- sync2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
- Otherwise: cnt <= cnt+1.
REQ-014 Latency SHALL be as follows: a clean input change appears on btn_stable exactly 2 + DEBOUNCE_CYCLES cycles after the first edge at which button is sampled at its new value.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES cycles at sync2 SHALL leave stable unchanged, and its counter SHALL restart from 0 on the next mismatch.
REQ-016 btn_rise[i] SHALL be 1 for exactly the cycle after stable[i] goes 0->1, and 0 otherwise; a 1->0 transition SHALL produce no pulse.
REQ-017 The five bits SHALL debounce independently; simultaneous transitions SHALL produce simultaneous pulses.
REQ-018 The sticky event register evt[4:0] SHALL set bit i when btn_rise[i]=1.
REQ-019 evt SHALL be cleared write-1-to-clear: when wen=1 and addr=0x07C, each bit i with wdata[i]=1 clears.
REQ-020 If set and clear of the same evt bit occur in the same cycle, the set SHALL win.
REQ-021 rdata SHALL be combinational with zero wait states:
- addr=0x078: {27'b0, btn_stable}.
- addr=0x07C: {27'b0, evt}.
- any other addr: 32'h0.
REQ-022 Writes to 0x078 or to any other address SHALL have no effect.
REQ-023 Reads SHALL have no side effects.
REQ-024 Counters SHALL never exceed DEBOUNCE_CYCLES-1, so no wrap-around is possible.

Reset
REQ-025 When rst=0 at a clock edge, the sync flops, stable, cnt, btn_rise and evt SHALL all be cleared to 0.
REQ-026 After reset, btn_stable and btn_rise SHALL read 0, and rdata SHALL be 0 for every address.
REQ-027 A reset asserted mid-debounce SHALL discard the partial count.
REQ-028 After reset deassertion, a still-pressed button SHALL be accepted after the full 2 + DEBOUNCE_CYCLES latency and SHALL raise btn_rise.

Structure
REQ-029 The address offsets (BTN_LVL_OFF=0x078, BTN_EVT_OFF=0x07C) SHALL live in the shared defines package beside the other peripheral offsets.
REQ-030 Per-bit logic (synchronizer, counter, stable, rise) SHALL be the sub-module debounce_cell, instantiated 5 times; the evt register and read mux SHALL stay in btn_debounce.

Verification (DEBOUNCE_CYCLES=4, CNT_W=3)
REQ-031 Reset with button=5'b11111 held: rdata is 0 throughout reset; btn_stable=5'b11111 at 6 cycles after release; btn_rise=5'b11111 for 1 cycle; read at 0x07C returns 32'h1F.
REQ-032 Set button[0]=1 for 3 cycles then 0 (bounce): btn_stable[0] stays 0 and evt stays 0.
REQ-033 Set button[2] from 0 to 1 clean: btn_stable[2]=1 exactly 6 cycles later; one btn_rise pulse; evt=5'b00100.
REQ-034 With evt=5'b00101, write 32'h4 to 0x07C: evt becomes 5'b00001; a write of 32'hFF to 0x078 changes nothing.
REQ-035 A W1C of bit 3 in the same cycle as the btn_rise[3] pulse: evt[3] remains 1.
REQ-036 Assert rst for 1 cycle when cnt[1]=3: btn_stable[1] stays 0 until a full 6 cycles after release.

Source files
------------

// File: rtl/btn_debounce_pkg.sv
// Shared peripheral definitions for the button debouncer: bus offsets and button count.
package btn_debounce_pkg;

    localparam int NUM_BTN = 5;

    localparam logic [11:0] BTN_LVL_OFF = 12'h078;
    localparam logic [11:0] BTN_EVT_OFF = 12'h07C;

endpackage

// File: rtl/btn_debounce_cell.sv
// One button bit: two-flop synchronizer, hold counter, debounced level and rising-edge pulse.
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic stable,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Any sample that agrees with the accepted level discards the partial count,
    // so a glitch shorter than DEBOUNCE_CYCLES never reaches stable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync2;
                cnt    <= '0;
                rise   <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Five-button debouncer peripheral: debounced levels, rise pulses and a W1C sticky event register.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_BTN-1:0]   button,
    input  logic [11:0]          addr,
    input  logic                 wen,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic [NUM_BTN-1:0]   btn_stable,
    output logic [NUM_BTN-1:0]   btn_rise
);

    logic [NUM_BTN-1:0] evt;
    logic [NUM_BTN-1:0] evt_clr;
    logic               unused_wdata;

    assign unused_wdata = ^wdata[31:NUM_BTN];

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .din   (button[i]),
            .stable(btn_stable[i]),
            .rise  (btn_rise[i])
        );
    end

    // Bus is zero-wait: a write takes effect at the edge where wen=1, reads are
    // combinational and side-effect free. No valid/ready handshake exists.
    assign evt_clr = (wen && addr == BTN_EVT_OFF) ? wdata[NUM_BTN-1:0] : '0;

    // A rise in the same cycle as its clear wins, so no event is ever lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            evt <= '0;
        end else begin
            evt <= (evt & ~evt_clr) | btn_rise;
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (addr)
            BTN_LVL_OFF: rdata = {{(32-NUM_BTN){1'b0}}, btn_stable};
            BTN_EVT_OFF: rdata = {{(32-NUM_BTN){1'b0}}, evt};
            default:     rdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce with DEBOUNCE_CYCLES=4: directed scenarios then random buttons/bus traffic.
module tb_btn_debounce;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  button;
    logic [11:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  btn_stable;
    logic [4:0]  btn_rise;

    int errors = 0;
    int checks = 0;

    btn_debounce #(.DEBOUNCE_CYCLES(N), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .button    (button),
        .addr      (addr),
        .wen       (wen),
        .wdata     (wdata),
        .rdata     (rdata),
        .btn_stable(btn_stable),
        .btn_rise  (btn_rise)
    );

    always #5 clk = ~clk;

    // Reference model: hist[0] is the button value taken at the previous edge.
    // A level is accepted when the N synchronized samples seen before the last
    // N edges all disagree with the current level.
    logic [4:0] hist [0:N];
    logic [4:0] stable_m = '0;
    logic [4:0] rise_m   = '0;
    logic [4:0] evt_m    = '0;

    always @(posedge clk) begin
        logic [4:0] clr;
        logic [4:0] new_rise;
        logic       all_diff;
        if (!rst) begin
            for (int j = 0; j <= N; j++) hist[j] = '0;
            stable_m = '0;
            rise_m   = '0;
            evt_m    = '0;
        end else begin
            clr      = (wen && addr == 12'h07C) ? wdata[4:0] : 5'h0;
            evt_m    = (evt_m & ~clr) | rise_m;
            new_rise = '0;
            for (int b = 0; b < 5; b++) begin
                all_diff = 1'b1;
                for (int j = 1; j <= N; j++)
                    if (hist[j][b] == stable_m[b]) all_diff = 1'b0;
                if (all_diff) begin
                    stable_m[b] = ~stable_m[b];
                    new_rise[b] = stable_m[b];
                end
            end
            rise_m = new_rise;
            for (int j = N; j >= 1; j--) hist[j] = hist[j-1];
            hist[0] = button;
        end
    end

    function automatic logic [31:0] exp_rdata(input logic [11:0] a);
        case (a)
            12'h078: return {27'b0, stable_m};
            12'h07C: return {27'b0, evt_m};
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic [4:0] b, input logic [11:0] a,
                        input logic w, input logic [31:0] d);
        @(negedge clk);
        rst = r; button = b; addr = a; wen = w; wdata = d;
        @(posedge clk);
        #1;
        chk("model_stable", {27'b0, btn_stable}, {27'b0, stable_m});
        chk("model_rise", {27'b0, btn_rise}, {27'b0, rise_m});
        chk("model_rdata", rdata, exp_rdata(a));
    endtask

    task automatic idle(input logic [4:0] b, input int n);
        for (int i = 0; i < n; i++) step(1'b1, b, 12'h078, 1'b0, 32'h0);
    endtask

    initial begin
        logic [4:0]  cur;
        logic [11:0] ra;
        rst = 1'b0; button = '0; addr = '0; wen = 1'b0; wdata = '0;

        // Reset with every button held
        step(1'b0, 5'h1F, 12'h078, 1'b0, 32'h0); chk("rst_rdata_lvl", rdata, 32'h0);
        step(1'b0, 5'h1F, 12'h07C, 1'b0, 32'h0); chk("rst_rdata_evt", rdata, 32'h0);
        step(1'b0, 5'h1F, 12'h100, 1'b0, 32'h0); chk("rst_rise", {27'b0, btn_rise}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            idle(5'h1F, 1);
            chk("rel_wait", {27'b0, btn_stable}, 32'h0);
        end
        idle(5'h1F, 1);
        chk("rel_stable", {27'b0, btn_stable}, 32'h1F);
        chk("rel_rise", {27'b0, btn_rise}, 32'h1F);
        step(1'b1, 5'h1F, 12'h07C, 1'b0, 32'h0);
        chk("rel_rise_end", {27'b0, btn_rise}, 32'h0);
        chk("rel_evt", rdata, 32'h1F);

        // Release everything (no pulses on falls), clear events
        idle(5'h00, 8);
        chk("fall_stable", {27'b0, btn_stable}, 32'h0);
        step(1'b1, 5'h00, 12'h07C, 1'b1, 32'h1F);
        chk("clr_all", rdata, 32'h0);

        // Bounce on bit 0 shorter than N
        idle(5'h01, 3);
        idle(5'h00, 8);
        chk("bounce_stable", {27'b0, btn_stable}, 32'h0);
        step(1'b1, 5'h00, 12'h07C, 1'b0, 32'h0);
        chk("bounce_evt", rdata, 32'h0);

        // Clean press of bit 2
        idle(5'h04, 5);
        chk("b2_wait", {27'b0, btn_stable}, 32'h0);
        idle(5'h04, 1);
        chk("b2_stable", {27'b0, btn_stable}, 32'h4);
        chk("b2_rise", {27'b0, btn_rise}, 32'h4);
        step(1'b1, 5'h04, 12'h07C, 1'b0, 32'h0);
        chk("b2_rise_end", {27'b0, btn_rise}, 32'h0);
        chk("b2_evt", rdata, 32'h4);

        // Build evt=00101, W1C bit 2, then a write to the level offset
        idle(5'h05, 6);
        step(1'b1, 5'h05, 12'h07C, 1'b0, 32'h0);
        chk("evt_05", rdata, 32'h5);
        step(1'b1, 5'h05, 12'h07C, 1'b1, 32'h4);
        chk("w1c_bit2", rdata, 32'h1);
        step(1'b1, 5'h05, 12'h078, 1'b1, 32'hFF);
        chk("lvl_write_lvl", rdata, 32'h5);
        step(1'b1, 5'h05, 12'h07C, 1'b0, 32'h0);
        chk("lvl_write_evt", rdata, 32'h1);

        // W1C of bit 3 in the same cycle as its rise pulse
        idle(5'h0D, 6);
        chk("b3_rise", {27'b0, btn_rise}, 32'h8);
        step(1'b1, 5'h0D, 12'h07C, 1'b1, 32'h8);
        chk("set_wins", rdata, 32'h9);
        step(1'b1, 5'h0D, 12'h07C, 1'b1, 32'h8);
        chk("clr_after", rdata, 32'h1);

        // Reset while bit 1 is mid-count
        idle(5'h0F, 5);
        step(1'b0, 5'h0F, 12'h078, 1'b0, 32'h0);
        chk("mid_rst", {27'b0, btn_stable}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            idle(5'h0F, 1);
            chk("mid_rst_wait", {27'b0, btn_stable}, 32'h0);
        end
        idle(5'h0F, 1);
        chk("mid_rst_stable", {27'b0, btn_stable}, 32'hF);
        chk("mid_rst_rise", {27'b0, btn_rise}, 32'hF);

        // Random buttons and bus traffic against the model
        cur = 5'h0F;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
            case ($urandom_range(0, 3))
                0:       ra = 12'h078;
                1, 2:    ra = 12'h07C;
                default: ra = 12'($urandom);
            endcase
            step(($urandom_range(0, 80) != 0), cur, ra,
                 ($urandom_range(0, 3) == 0), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
